// File: rtl/md_reg_if.sv
// md_reg_if: bundles the md_reg_ctl bus-side signals.
//   master modport : processor/memory side, drives strobes, read data, spy
//                    writes and error clear; observes MD and status.
//   slave modport  : md_reg_ctl side.
// Signals
//   state_alu/write/mmu/fetch : processor cycle-state strobes
//   memrq, mem_ack            : read issued / read data valid pulses
//   mds, mds_par              : MD source bus and its even-parity bit
//   destmdr, srcmd            : instruction writes / sources MD
//   spy_in, spy_sel, ldmd_spy : chunked debug load of MD
//   clr_err                   : clear sticky error flags
//   md, mddrive, mdgetspar, md_wait, md_busy, md_timeout, md_parerr : outputs
interface md_reg_if #(
  parameter int DATA_W = 32,
  parameter int SPY_W  = 16,
  parameter int SEL_W  = 1
);
  logic              state_alu;
  logic              state_write;
  logic              state_mmu;
  logic              state_fetch;
  logic              memrq;
  logic              mem_ack;
  logic [DATA_W-1:0] mds;
  logic              mds_par;
  logic              destmdr;
  logic              srcmd;
  logic [SPY_W-1:0]  spy_in;
  logic [SEL_W-1:0]  spy_sel;
  logic              ldmd_spy;
  logic              clr_err;
  logic [DATA_W-1:0] md;
  logic              mddrive;
  logic              mdgetspar;
  logic              md_wait;
  logic              md_busy;
  logic              md_timeout;
  logic              md_parerr;

  modport master (
    output state_alu, state_write, state_mmu, state_fetch, memrq, mem_ack,
           mds, mds_par, destmdr, srcmd, spy_in, spy_sel, ldmd_spy, clr_err,
    input  md, mddrive, mdgetspar, md_wait, md_busy, md_timeout, md_parerr
  );

  modport slave (
    input  state_alu, state_write, state_mmu, state_fetch, memrq, mem_ack,
           mds, mds_par, destmdr, srcmd, spy_in, spy_sel, ldmd_spy, clr_err,
    output md, mddrive, mdgetspar, md_wait, md_busy, md_timeout, md_parerr
  );
endinterface

// File: rtl/md_reg_ctl.sv
// md_reg_ctl: memory data register (MD) with its own read-completion
// controller. MD is loaded from memory read data, from ALU results (both via
// mds) or chunk-wise from the spy bus. While a read is outstanding the
// processor is stalled if it touches MD; a read that is never acknowledged
// within TIMEOUT cycles fills MD with all ones and raises a sticky flag.
//
// Ports
//   clk   : clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : md_reg_if.slave, all data/handshake/status signals
//
// Build option
//   MD_PARITY_EN : when defined, even parity on captured read data is checked
//                  and md_parerr becomes a live sticky flag; otherwise
//                  md_parerr is tied low and mds_par is ignored.
module md_reg_ctl #(
  parameter int DATA_W  = 32,
  parameter int SPY_W   = 16,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     reset,
  md_reg_if.slave  bus
);

  localparam int NCHUNK = DATA_W / SPY_W;
  localparam int CNT_W  = 16;

  typedef enum logic {IDLE, PEND} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   md_q, md_d;
  logic                tmo_q, tmo_d;
  logic                pend;
  logic                cap;
  logic                lost;
  logic                alu_ld;

  assign pend   = (state_q == PEND);
  assign cap    = pend & bus.mem_ack;
  // Lost read: the final allowed PEND cycle passes without an acknowledge.
  assign lost   = pend & ~bus.mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign alu_ld = bus.state_alu & bus.destmdr & ~pend;

  // MD next value: read capture / timeout fill, then ALU load, then spy chunk.
  always_comb begin
    md_d = md_q;
    if (cap) begin
      md_d = bus.mds;
    end else if (lost) begin
      md_d = '1;
    end else if (alu_ld) begin
      md_d = bus.mds;
    end else if (bus.ldmd_spy) begin
      // An index with no matching chunk simply loads nothing.
      for (int k = 0; k < NCHUNK; k++) begin
        if (bus.spy_sel == SEL_W'(k)) md_d[k*SPY_W +: SPY_W] = bus.spy_in;
      end
    end
  end

  // A flag-setting event wins over a simultaneous clear.
  always_comb begin
    tmo_d = tmo_q;
    if (lost)             tmo_d = 1'b1;
    else if (bus.clr_err) tmo_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      md_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      md_q  <= md_d;
      tmo_q <= tmo_d;
      case (state_q)
        IDLE: begin
          if (bus.memrq) begin
            state_q <= PEND;
            cnt_q   <= '0;
          end
        end
        PEND: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_ack) begin
            // Back-to-back read: a new request alongside the ack restarts.
            if (bus.memrq) cnt_q   <= '0;
            else           state_q <= IDLE;
          end else if (lost) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MD_PARITY_EN
  logic perr_q, perr_d;
  logic mdhaspar_q;

  always_comb begin
    perr_d = perr_q;
    if (cap && (bus.mds_par != ^bus.mds)) perr_d = 1'b1;
    else if (bus.clr_err)                 perr_d = 1'b0;
  end

  // Tracks whether MD currently holds data that came with source parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q     <= 1'b0;
      mdhaspar_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      if (cap || alu_ld)                 mdhaspar_q <= ~bus.destmdr;
      else if (lost || bus.ldmd_spy)     mdhaspar_q <= 1'b0;
    end
  end

  assign bus.md_parerr = perr_q;
`else
  assign bus.md_parerr = 1'b0;
`endif

  assign bus.md         = md_q;
  assign bus.md_busy    = pend;
  assign bus.md_timeout = tmo_q;
  assign bus.md_wait    = pend & (bus.srcmd | bus.destmdr);
  assign bus.mddrive    = bus.srcmd & (bus.state_alu | bus.state_write |
                                       bus.state_mmu | bus.state_fetch);
  assign bus.mdgetspar  = ~bus.destmdr;

endmodule

// File: tb/tb_md_reg_ctl.sv
module tb_md_reg_ctl;
  localparam int DATA_W  = 32;
  localparam int SPY_W   = 16;
  localparam int SEL_W   = 1;
  localparam int TIMEOUT = 8;
  localparam int NCH     = DATA_W / SPY_W;

  typedef struct packed {
    logic              rst;
    logic              alu, wr, mmu, fetch;
    logic              memrq, ack;
    logic [DATA_W-1:0] mds;
    logic              par;
    logic              destmdr, srcmd;
    logic [SPY_W-1:0]  spy_in;
    logic [SEL_W-1:0]  spy_sel;
    logic              ldspy, clr;
  } stim_t;

  typedef struct packed {
    logic [DATA_W-1:0] md;
    logic busy, tmo, perr, drive, getspar, wt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_reg_if #(.DATA_W(DATA_W), .SPY_W(SPY_W), .SEL_W(SEL_W)) bus ();

  md_reg_ctl #(.DATA_W(DATA_W), .SPY_W(SPY_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a pending-read flag plus how long it has been waiting.
  logic [DATA_W-1:0] m_md;
  bit   m_out;
  int   m_age;
  bit   m_tmo, m_perr;

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit was_out, got, lost, perr_hit;
    int sel;
    reset           = s.rst;
    bus.state_alu   = s.alu;
    bus.state_write = s.wr;
    bus.state_mmu   = s.mmu;
    bus.state_fetch = s.fetch;
    bus.memrq       = s.memrq;
    bus.mem_ack     = s.ack;
    bus.mds         = s.mds;
    bus.mds_par     = s.par;
    bus.destmdr     = s.destmdr;
    bus.srcmd       = s.srcmd;
    bus.spy_in      = s.spy_in;
    bus.spy_sel     = s.spy_sel;
    bus.ldmd_spy    = s.ldspy;
    bus.clr_err     = s.clr;
    if (s.rst) begin
      m_md = '0; m_out = 0; m_age = 0; m_tmo = 0; m_perr = 0;
    end else begin
      was_out = m_out;
      got  = was_out && s.ack;
      lost = was_out && !s.ack && (m_age == TIMEOUT - 1);
      sel  = int'(s.spy_sel);
      if (got)                                    m_md = s.mds;
      else if (lost)                              m_md = {DATA_W{1'b1}};
      else if (s.alu && s.destmdr && !was_out)    m_md = s.mds;
      else if (s.ldspy && sel < NCH)              m_md[sel*SPY_W +: SPY_W] = s.spy_in;
      perr_hit = 0;
`ifdef MD_PARITY_EN
      perr_hit = got && (s.par != ($countones(s.mds) % 2 == 1));
`endif
      if (lost)       m_tmo = 1; else if (s.clr) m_tmo = 0;
      if (perr_hit)   m_perr = 1; else if (s.clr) m_perr = 0;
      if (was_out) begin
        if (got && s.memrq)  m_age = 0;
        else if (got || lost) m_out = 0;
        else                  m_age++;
      end else if (s.memrq) begin
        m_out = 1;
        m_age = 0;
      end
    end
    e.md      = m_md;
    e.busy    = m_out;
    e.tmo     = m_tmo;
    e.perr    = m_perr;
    e.drive   = s.srcmd & (s.alu | s.wr | s.mmu | s.fetch);
    e.getspar = ~s.destmdr;
    e.wt      = m_out & (s.srcmd | s.destmdr);
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("md",         64'(bus.md),         64'(e.md));
        chk("md_busy",    64'(bus.md_busy),    64'(e.busy));
        chk("md_timeout", 64'(bus.md_timeout), 64'(e.tmo));
        chk("md_parerr",  64'(bus.md_parerr),  64'(e.perr));
        chk("mddrive",    64'(bus.mddrive),    64'(e.drive));
        chk("mdgetspar",  64'(bus.mdgetspar),  64'(e.getspar));
        chk("md_wait",    64'(bus.md_wait),    64'(e.wt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    // reset
    s = quiet(); s.rst = 1;
    apply(s); apply(s);
    // read completes after three waiting cycles, srcmd stalls meanwhile
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); s.srcmd = 1; s.alu = 1;
    repeat (3) apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h1234_5678; s.par = ^s.mds; apply(s);
    s = quiet(); apply(s);
    // lost read, late ack ignored, then clear
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); repeat (TIMEOUT + 2) apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'hAAAA_AAAA; apply(s);
    s = quiet(); s.clr = 1; apply(s);
    // ALU load when idle, blocked while pending
    s = quiet(); s.alu = 1; s.destmdr = 1; s.mds = 32'hCAFE_0001; apply(s);
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); s.alu = 1; s.destmdr = 1; s.mds = 32'h5555_0002; apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h0000_00F0; apply(s);
    // spy chunk loads, then ack beats a coincident spy load
    s = quiet(); s.ldspy = 1; s.spy_sel = 1; s.spy_in = 16'hBEEF; apply(s);
    s = quiet(); s.ldspy = 1; s.spy_sel = 0; s.spy_in = 16'h0F0F; apply(s);
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h7654_3210; s.ldspy = 1; s.spy_in = 16'hDEAD; apply(s);
    // parity: bad then good
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h0000_0001; s.par = 0; apply(s);
    s = quiet(); s.clr = 1; apply(s);
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h0000_0001; s.par = 1; apply(s);
    // back-to-back reads
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); apply(s); apply(s);
    s = quiet(); s.ack = 1; s.memrq = 1; s.mds = 32'h1111_2222; apply(s);
    s = quiet(); repeat (TIMEOUT - 2) apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h3333_4444; apply(s);
    // reset mid-read, following ack ignored
    s = quiet(); s.memrq = 1; apply(s);
    s = quiet(); apply(s);
    s = quiet(); s.rst = 1; apply(s);
    s = quiet(); s.ack = 1; s.mds = 32'h9999_9999; apply(s);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 199) == 0);
      s.alu     = 1'($urandom);
      s.wr      = 1'($urandom);
      s.mmu     = 1'($urandom);
      s.fetch   = 1'($urandom);
      s.memrq   = ($urandom_range(0, 5) == 0);
      s.ack     = ($urandom_range(0, 6) == 0);
      s.mds     = $urandom;
      s.par     = 1'($urandom);
      s.destmdr = 1'($urandom);
      s.srcmd   = 1'($urandom);
      s.spy_in  = 16'($urandom);
      s.spy_sel = SEL_W'($urandom);
      s.ldspy   = ($urandom_range(0, 3) == 0);
      s.clr     = ($urandom_range(0, 29) == 0);
      apply(s);
    end
    s = quiet(); apply(s);
    repeat (3) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
